// File: rtl/weight_fetch_sequencer.sv
// ============================================================================
// weight_fetch_sequencer : arbitrates host writes and streamed weight reads
//                          for one single-port weight BRAM feeding a MAC.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module weight_fetch_sequencer #(
   parameter int DEPTH  = 28,
   parameter int ADDR_W = 5,
   parameter int DATA_W = 16
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              START,
   output logic              BUSY,
   output logic              DONE,
   input  logic              LD_VALID,
   output logic              LD_READY,
   input  logic [ADDR_W-1:0] LD_ADDR,
   input  logic [DATA_W-1:0] LD_DATA,
   output logic              LD_ERR,
   output logic [ADDR_W-1:0] BRAM_ADDR,
   output logic [DATA_W-1:0] BRAM_DI,
   output logic              BRAM_EN,
   output logic              BRAM_WE,
   input  logic [DATA_W-1:0] BRAM_DO,
   output logic              W_VALID,
   input  logic              W_READY,
   output logic [DATA_W-1:0] W_DATA,
   output logic [ADDR_W-1:0] W_INDEX,
   output logic              W_LAST
);

   // One extra pointer bit so the saturated value DEPTH is representable
   // even when DEPTH == 2**ADDR_W.
   localparam int                PTR_W    = ADDR_W + 1;
   localparam logic [PTR_W-1:0]  DEPTH_P  = PTR_W'(DEPTH);
   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   state_t              state_q,   state_d;
   logic [PTR_W-1:0]    rd_ptr_q,  rd_ptr_d;
   logic                w_valid_q, w_valid_d;
   logic [ADDR_W-1:0]   w_index_q, w_index_d;
   logic                done_q,    done_d;
   logic                ld_err_q,  ld_err_d;

   logic                ld_in_range;
   logic                issue;
   logic                handshake;

   assign ld_in_range = {1'b0, LD_ADDR} < DEPTH_P;
   assign handshake   = w_valid_q && W_READY;

   assign BUSY    = (state_q == ST_RUN);
   assign DONE    = done_q;
   assign LD_ERR  = ld_err_q;
   assign W_VALID = w_valid_q;
   assign W_INDEX = w_index_q;
   assign W_LAST  = w_valid_q && (w_index_q == LAST_IDX);
   assign W_DATA  = BRAM_DO;
   assign BRAM_DI = LD_DATA;

   always_comb begin
      state_d   = state_q;
      rd_ptr_d  = rd_ptr_q;
      w_valid_d = w_valid_q;
      w_index_d = w_index_q;
      done_d    = 1'b0;
      ld_err_d  = 1'b0;
      LD_READY  = 1'b0;
      BRAM_EN   = 1'b0;
      BRAM_WE   = 1'b0;
      BRAM_ADDR = '0;
      issue     = 1'b0;

      case (state_q)
         ST_IDLE: begin
            w_valid_d = 1'b0;
            LD_READY  = LD_VALID && !START;
            if (LD_READY) begin
               if (ld_in_range) begin
                  BRAM_EN   = 1'b1;
                  BRAM_WE   = 1'b1;
                  BRAM_ADDR = LD_ADDR;
               end else begin
                  ld_err_d = 1'b1;
               end
            end
            if (START) begin
               state_d  = ST_RUN;
               rd_ptr_d = '0;
            end
         end

         ST_RUN: begin
            // Holding EN low on a stall freezes BRAM DO, which keeps W_DATA stable.
            issue = (rd_ptr_q < DEPTH_P) && (!w_valid_q || W_READY);
            if (handshake) begin
               w_valid_d = 1'b0;
            end
            if (issue) begin
               BRAM_EN   = 1'b1;
               BRAM_ADDR = rd_ptr_q[ADDR_W-1:0];
               rd_ptr_d  = rd_ptr_q + PTR_W'(1);
               w_valid_d = 1'b1;
               w_index_d = rd_ptr_q[ADDR_W-1:0];
            end
            if (handshake && W_LAST) begin
               state_d   = ST_IDLE;
               done_d    = 1'b1;
               w_valid_d = 1'b0;
            end
         end

         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q   <= ST_IDLE;
         rd_ptr_q  <= '0;
         w_valid_q <= 1'b0;
         w_index_q <= '0;
         done_q    <= 1'b0;
         ld_err_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         rd_ptr_q  <= rd_ptr_d;
         w_valid_q <= w_valid_d;
         w_index_q <= w_index_d;
         done_q    <= done_d;
         ld_err_q  <= ld_err_d;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_weight_fetch_sequencer.sv
// ============================================================================
// tb_weight_fetch_sequencer : self-checking bench with a BRAM model and a
//                             shadow-memory reference of the weight store.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_weight_fetch_sequencer;

   localparam int DEPTH  = 28;
   localparam int ADDR_W = 5;
   localparam int DATA_W = 16;

   logic              CLK = 1'b0;
   logic              RST;
   logic              START;
   logic              BUSY;
   logic              DONE;
   logic              LD_VALID;
   logic              LD_READY;
   logic [ADDR_W-1:0] LD_ADDR;
   logic [DATA_W-1:0] LD_DATA;
   logic              LD_ERR;
   logic [ADDR_W-1:0] BRAM_ADDR;
   logic [DATA_W-1:0] BRAM_DI;
   logic              BRAM_EN;
   logic              BRAM_WE;
   logic [DATA_W-1:0] BRAM_DO;
   logic              W_VALID;
   logic              W_READY;
   logic [DATA_W-1:0] W_DATA;
   logic [ADDR_W-1:0] W_INDEX;
   logic              W_LAST;

   weight_fetch_sequencer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .CLK(CLK), .RST(RST), .START(START), .BUSY(BUSY), .DONE(DONE),
      .LD_VALID(LD_VALID), .LD_READY(LD_READY), .LD_ADDR(LD_ADDR), .LD_DATA(LD_DATA),
      .LD_ERR(LD_ERR), .BRAM_ADDR(BRAM_ADDR), .BRAM_DI(BRAM_DI), .BRAM_EN(BRAM_EN),
      .BRAM_WE(BRAM_WE), .BRAM_DO(BRAM_DO), .W_VALID(W_VALID), .W_READY(W_READY),
      .W_DATA(W_DATA), .W_INDEX(W_INDEX), .W_LAST(W_LAST)
   );

   always #5 CLK = ~CLK;

   // Single-port BRAM with negedge-registered output
   logic [DATA_W-1:0] mem [0:31];
   always @(negedge CLK) begin
      if (BRAM_EN) begin
         if (BRAM_WE) mem[BRAM_ADDR] <= BRAM_DI;
         else         BRAM_DO        <= mem[BRAM_ADDR];
      end
   end

   // Reference: what the weight store must contain after every accepted write
   logic [DATA_W-1:0] shadow [0:31];
   int vectors     = 0;
   int miscompares = 0;
   bit exp_err     = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Inputs are driven at posedge+1, outputs sampled at posedge+2
   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic load(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
      bit in_range;
      in_range = (a < DEPTH);
      tick();
      START = 1'b0; W_READY = 1'b0;
      LD_VALID = 1'b1; LD_ADDR = a; LD_DATA = d;
      #1;
      chk("ld_err_prev", LD_ERR, exp_err);
      chk("ld_ready", LD_READY, 1);
      chk("bram_en_wr", BRAM_EN, in_range);
      chk("bram_we_wr", BRAM_WE, in_range);
      if (in_range) begin
         chk("bram_addr_wr", BRAM_ADDR, a);
         chk("bram_di", BRAM_DI, d);
         shadow[a] = d;
      end
      exp_err = !in_range;
   endtask

   task automatic ld_end();
      tick();
      LD_VALID = 1'b0;
      #1;
      chk("ld_err_last", LD_ERR, exp_err);
      chk("ld_ready_idle", LD_READY, 0);
      exp_err = 1'b0;
   endtask

   task automatic do_run(input bit rnd, input bit conflict, input int abort_at);
      int   exp_idx  = 0;
      int   it       = 0;
      bit   exp_done = 1'b0;
      bit   finished = 1'b0;
      bit   aborted  = 1'b0;
      bit   pv = 1'b0, pr = 1'b0;
      logic [DATA_W-1:0] pd = '0;
      logic [ADDR_W-1:0] pi = '0;

      tick();
      START = 1'b1; W_READY = 1'b0;
      LD_VALID = conflict; LD_ADDR = ADDR_W'($urandom_range(0, DEPTH-1)); LD_DATA = DATA_W'($urandom);
      #1;
      chk("busy_pre", BUSY, 0);
      chk("start_ld_ready", LD_READY, 0);
      chk("start_we", BRAM_WE, 0);

      while (!finished && it < 400) begin
         tick();
         it++;
         START    = exp_done ? 1'b0 : 1'($urandom % 2);
         LD_VALID = exp_done ? 1'b0 : 1'($urandom % 2);
         LD_ADDR  = ADDR_W'($urandom);
         LD_DATA  = DATA_W'($urandom);
         W_READY  = rnd ? 1'($urandom % 4 != 0) : 1'b1;
         #1;
         chk("done", DONE, exp_done);
         chk("busy", BUSY, !exp_done);
         if (!rnd) chk("done_cycle", DONE, it == DEPTH + 2);
         if (exp_done) begin
            chk("valid_after_last", W_VALID, 0);
            finished = 1'b1;
         end else begin
            chk("ld_ready_run", LD_READY, 0);
            chk("we_run", BRAM_WE, 0);
            if (!rnd) chk("valid_timing", W_VALID, (it >= 2) && (it <= DEPTH + 1));
            if (pv && !pr) begin
               chk("stall_valid", W_VALID, 1);
               chk("stall_data", W_DATA, pd);
               chk("stall_index", W_INDEX, pi);
            end
            if (W_VALID) begin
               chk("w_index", W_INDEX, exp_idx);
               chk("w_data", W_DATA, shadow[exp_idx]);
               chk("w_last", W_LAST, exp_idx == DEPTH - 1);
            end
            if (abort_at >= 0 && W_VALID && W_INDEX == abort_at) begin
               tick();
               RST = 1'b1; START = 1'b0; LD_VALID = 1'b0;
               tick();
               RST = 1'b0;
               #1;
               chk("abort_valid", W_VALID, 0);
               chk("abort_busy", BUSY, 0);
               chk("abort_done", DONE, 0);
               chk("abort_index", W_INDEX, 0);
               for (int k = 0; k < 3; k++) begin
                  tick();
                  #1;
                  chk("abort_no_done", DONE, 0);
                  chk("abort_idle", BUSY, 0);
               end
               aborted  = 1'b1;
               finished = 1'b1;
            end else begin
               if (W_VALID && W_READY) begin
                  if (exp_idx == DEPTH - 1) exp_done = 1'b1;
                  exp_idx++;
               end
               pv = W_VALID; pr = W_READY; pd = W_DATA; pi = W_INDEX;
            end
         end
      end

      chk("run_terminated", finished, 1);
      if (!aborted) begin
         chk("word_count", exp_idx, DEPTH);
         tick();
         START = 1'b0; LD_VALID = 1'b0; W_READY = 1'b0;
         #1;
         chk("done_single", DONE, 0);
         chk("valid_idle", W_VALID, 0);
      end
   endtask

   initial begin
      RST = 1'b1; START = 1'b0; LD_VALID = 1'b0; W_READY = 1'b0;
      LD_ADDR = '0; LD_DATA = '0;
      tick();
      tick();
      RST = 1'b0;
      #1;
      chk("rst_busy", BUSY, 0);
      chk("rst_valid", W_VALID, 0);
      chk("rst_done", DONE, 0);
      chk("rst_ld_err", LD_ERR, 0);
      chk("rst_index", W_INDEX, 0);
      chk("rst_bram_en", BRAM_EN, 0);

      // Directed load of ramp weights, then a full-speed run
      for (int i = 0; i < DEPTH; i++) load(ADDR_W'(i), DATA_W'(16'h0100 + i));
      ld_end();
      do_run(1'b0, 1'b0, -1);

      // Random weights with an out-of-range write mixed in, random stalls
      for (int i = 0; i < DEPTH; i++) begin
         load(ADDR_W'(i), DATA_W'($urandom));
         if (i == 13) load(5'd30, 16'hDEAD);
      end
      ld_end();
      do_run(1'b1, 1'b0, -1);

      // Dropped writes must leave contents intact; START beats LD_VALID
      load(5'd30, 16'hBEEF);
      load(5'd31, 16'hCAFE);
      load(5'd2, 16'h1234);
      ld_end();
      do_run(1'b1, 1'b1, -1);

      // Reset mid-run, then a clean run from index 0
      do_run(1'b1, 1'b0, 10);
      do_run(1'b0, 1'b0, -1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

`default_nettype wire
